// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack bus with byte strobes, stall,
// aligned load extraction with sign/zero extension, misalign and timeout flags.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_valid, mem_mem_read,
//   mem_mem_write            EX/MEM live instruction and access kind
//   mem_alu_result           byte address
//   mem_rs2_val_for_store    LSB-aligned store data
//   mem_load_size,
//   mem_store_size           00 byte, 01 half, 1x word
//   mem_load_signed          sign-extend the load
//   stall_mem                hold EX/MEM and upstream
//   load_data,
//   load_data_valid          extended load result for writeback
//   misaligned               access rejected, no bus traffic
//   bus_err                  access aborted after timeout
//   dbus_*                   data bus request/response
`timescale 1ns/1ps
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rs2_val_for_store,
    input  logic [1:0]  mem_load_size,
    input  logic [1:0]  mem_store_size,
    input  logic        mem_load_signed,
    output logic        stall_mem,
    output logic [31:0] load_data,
    output logic        load_data_valid,
    output logic        misaligned,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        rd_q, rd_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] ld_q, ld_d;
    logic        ldv_q, ldv_d;
    logic        berr_q, berr_d;

    logic        start;
    logic [1:0]  size_sel;
    logic [1:0]  off_in;
    logic        aligned;
    logic [31:0] wdata_new;
    logic [3:0]  wstrb_new;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ext;

    // Reset gating keeps stall/misaligned quiet while rst is held.
    assign start    = !rst && (state_q == S_IDLE) && mem_valid &&
                      (mem_mem_read || mem_mem_write);
    assign size_sel = mem_mem_write ? mem_store_size : mem_load_size;
    assign off_in   = mem_alu_result[1:0];

    always_comb begin
        case (size_sel)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !off_in[0];
            default: aligned = (off_in == 2'b00);
        endcase
    end

    always_comb begin
        case (size_sel)
            2'b00: begin
                wdata_new = {4{mem_rs2_val_for_store[7:0]}};
                wstrb_new = 4'b0001 << off_in;
            end
            2'b01: begin
                wdata_new = {2{mem_rs2_val_for_store[15:0]}};
                wstrb_new = 4'b0011 << off_in;
            end
            default: begin
                wdata_new = mem_rs2_val_for_store;
                wstrb_new = 4'b1111;
            end
        endcase
        if (!mem_mem_write) begin
            wstrb_new = 4'b0000;
        end
    end

    // Load lane extraction and extension from the latched access shape.
    always_comb begin
        case (off_q)
            2'd0:    bsel = dbus_rdata[7:0];
            2'd1:    bsel = dbus_rdata[15:8];
            2'd2:    bsel = dbus_rdata[23:16];
            default: bsel = dbus_rdata[31:24];
        endcase
        hsel = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (size_q)
            2'b00:   ext = {{24{sgn_q & bsel[7]}}, bsel};
            2'b01:   ext = {{16{sgn_q & hsel[15]}}, hsel};
            default: ext = dbus_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        rd_d       = rd_q;
        off_d      = off_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        ld_d       = ld_q;
        ldv_d      = 1'b0;
        berr_d     = 1'b0;
        stall_mem  = 1'b0;
        misaligned = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (aligned) begin
                        stall_mem = 1'b1;
                        addr_d    = {mem_alu_result[31:2], 2'b00};
                        we_d      = mem_mem_write;
                        // A write wins when both are set; no load result.
                        rd_d      = mem_mem_read && !mem_mem_write;
                        off_d     = off_in;
                        size_d    = size_sel;
                        sgn_d     = mem_load_signed;
                        wdata_d   = mem_mem_write ? wdata_new : 32'h0;
                        wstrb_d   = wstrb_new;
                        state_d   = S_REQ;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            S_REQ: begin
                stall_mem = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (dbus_ack) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (rd_q) begin
                        ld_d  = ext;
                        ldv_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    berr_d  = 1'b1;
                    ld_d    = 32'h0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            cnt_q   <= '0;
            ld_q    <= 32'h0;
            ldv_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            ldv_q   <= ldv_d;
            berr_q  <= berr_d;
        end
    end

    assign dbus_req        = (state_q == S_REQ);
    assign dbus_we         = we_q;
    assign dbus_addr       = addr_q;
    assign dbus_wdata      = wdata_q;
    assign dbus_wstrb      = wstrb_q;
    assign load_data       = ld_q;
    assign load_data_valid = ldv_q;
    assign bus_err         = berr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed plan cases plus
// randomized accesses against a byte-lane arithmetic reference model.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_rs2_val_for_store;
    logic [1:0]  mem_load_size;
    logic [1:0]  mem_store_size;
    logic        mem_load_signed;
    logic        stall_mem;
    logic [31:0] load_data;
    logic        load_data_valid;
    logic        misaligned;
    logic        bus_err;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid),
        .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write),
        .mem_alu_result(mem_alu_result),
        .mem_rs2_val_for_store(mem_rs2_val_for_store),
        .mem_load_size(mem_load_size),
        .mem_store_size(mem_store_size),
        .mem_load_signed(mem_load_signed),
        .stall_mem(stall_mem),
        .load_data(load_data),
        .load_data_valid(load_data_valid),
        .misaligned(misaligned),
        .bus_err(bus_err),
        .dbus_req(dbus_req),
        .dbus_we(dbus_we),
        .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata),
        .dbus_wstrb(dbus_wstrb),
        .dbus_ack(dbus_ack),
        .dbus_rdata(dbus_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: access width in bytes, then plain shifts/masks.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_aligned(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(sz)) == 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd,
                                             input logic [1:0] sz,
                                             input logic [1:0] off,
                                             input logic sgn);
        int nb;
        logic [31:0] v, mask;
        nb = nbytes(sz);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v = (rd >> (8 * int'(off))) & mask;
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d,
                                              input logic [1:0] sz);
        logic [31:0] r;
        int nb;
        nb = nbytes(sz);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(d >> (8 * (i % nb)));
        return r;
    endfunction

    function automatic logic [3:0] exp_wstrb(input bit wr,
                                             input logic [1:0] sz,
                                             input logic [1:0] off);
        int m;
        if (!wr) return 4'b0000;
        m = ((1 << nbytes(sz)) - 1) << int'(off);
        return 4'(m);
    endfunction

    task automatic idle_inputs();
        mem_valid = 0; mem_mem_read = 0; mem_mem_write = 0;
        mem_alu_result = 0; mem_rs2_val_for_store = 0;
        mem_load_size = 0; mem_store_size = 0; mem_load_signed = 0;
        dbus_ack = 0; dbus_rdata = 0;
    endtask

    // Drives one access from IDLE through DONE and checks every phase.
    task automatic run_access(input bit rd, input bit wr,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] lsz, input logic [1:0] ssz,
                              input bit sgn, input int waitc,
                              input logic [31:0] rdata, input string tag);
        logic [1:0] sz;
        bit al, tmo, is_ld;
        int n, exp_n;
        logic [31:0] ea;
        sz = wr ? ssz : lsz;
        al = is_aligned(sz, a);
        tmo = (waitc >= TMO);
        is_ld = rd && !wr;
        exp_n = tmo ? TMO : waitc + 1;
        ea = {a[31:2], 2'b00};
        @(negedge clk);
        mem_valid = 1; mem_mem_read = rd; mem_mem_write = wr;
        mem_alu_result = a; mem_rs2_val_for_store = d;
        mem_load_size = lsz; mem_store_size = ssz; mem_load_signed = sgn;
        #1;
        checks++;
        if (stall_mem !== al || misaligned !== !al || dbus_req !== 1'b0) begin
            failures++;
            $display("FAIL %s start: stall=%b mis=%b req=%b want stall=%b mis=%b req=0",
                     tag, stall_mem, misaligned, dbus_req, al, !al);
        end
        if (!al) begin
            @(negedge clk);
            #1;
            checks++;
            if (dbus_req !== 1'b0 || stall_mem !== al) begin
                failures++;
                $display("FAIL %s misaligned_nobus: req=%b stall=%b want 0/0",
                         tag, dbus_req, stall_mem);
            end
            mem_valid = 0;
        end else begin
            @(negedge clk);
            for (n = 0; n < 200; n++) begin
                if (dbus_req !== 1'b1) break;
                if (n == 0) begin
                    checks++;
                    if (stall_mem !== 1'b1 || dbus_addr !== ea ||
                        dbus_we !== wr || dbus_wstrb !== exp_wstrb(wr, sz, a[1:0])) begin
                        failures++;
                        $display("FAIL %s req: stall=%b addr=%h we=%b strb=%b want 1 %h %b %b",
                                 tag, stall_mem, dbus_addr, dbus_we, dbus_wstrb,
                                 ea, wr, exp_wstrb(wr, sz, a[1:0]));
                    end
                    if (wr) begin
                        checks++;
                        if (dbus_wdata !== exp_wdata(d, sz)) begin
                            failures++;
                            $display("FAIL %s wdata: got %h want %h",
                                     tag, dbus_wdata, exp_wdata(d, sz));
                        end
                    end
                end
                if (n == waitc) begin
                    dbus_ack = 1; dbus_rdata = rdata;
                end
                @(negedge clk);
                dbus_ack = 0;
                dbus_rdata = $urandom;
            end
            #1;
            checks++;
            if (n !== exp_n) begin
                failures++;
                $display("FAIL %s req_cycles: got %0d want %0d", tag, n, exp_n);
            end
            checks++;
            if (stall_mem !== 1'b0 || load_data_valid !== (is_ld && !tmo) ||
                bus_err !== tmo) begin
                failures++;
                $display("FAIL %s done: stall=%b ldv=%b err=%b want 0 %b %b",
                         tag, stall_mem, load_data_valid, bus_err, is_ld && !tmo, tmo);
            end
            if (is_ld || tmo) begin
                checks++;
                if (load_data !== (tmo ? 32'h0 : exp_load(rdata, sz, a[1:0], sgn))) begin
                    failures++;
                    $display("FAIL %s load_data: got %h want %h", tag, load_data,
                             tmo ? 32'h0 : exp_load(rdata, sz, a[1:0], sgn));
                end
            end
            @(negedge clk);
            mem_valid = 0;
            #1;
            checks++;
            if (load_data_valid !== 1'b0 || bus_err !== 1'b0 ||
                stall_mem !== 1'b0 || dbus_req !== 1'b0) begin
                failures++;
                $display("FAIL %s back_idle: ldv=%b err=%b stall=%b req=%b want 0",
                         tag, load_data_valid, bus_err, stall_mem, dbus_req);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        #1;
        checks++;
        if ({dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, load_data,
             load_data_valid, bus_err, stall_mem} !== '0) begin
            failures++;
            $display("FAIL reset: req=%b we=%b addr=%h wd=%h strb=%b ld=%h ldv=%b err=%b want all 0",
                     dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
                     load_data, load_data_valid, bus_err);
        end
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_word_load();
        run_access(1, 0, 32'h100, 0, 2'b10, 0, 0, 0, 32'hDEADBEEF, "word_load");
    endtask

    task automatic test_byte_load();
        run_access(1, 0, 32'h103, 0, 2'b00, 0, 1, 1, 32'h80112233, "byte_ld_s");
        run_access(1, 0, 32'h103, 0, 2'b00, 0, 0, 2, 32'h80112233, "byte_ld_u");
        run_access(1, 0, 32'h102, 0, 2'b01, 0, 1, 0, 32'h80F01234, "half_ld_s");
    endtask

    task automatic test_half_store();
        run_access(0, 1, 32'h102, 32'h0000ABCD, 0, 2'b01, 0, 0, 0, "half_store");
        run_access(0, 1, 32'h101, 32'h000000EE, 0, 2'b00, 0, 1, 0, "byte_store");
    endtask

    task automatic test_misaligned();
        run_access(1, 0, 32'h101, 0, 2'b10, 0, 0, 0, 0, "mis_word");
        run_access(0, 1, 32'h103, 32'h1234, 0, 2'b01, 0, 0, 0, "mis_half");
    endtask

    task automatic test_timeout();
        run_access(1, 0, 32'h40, 0, 2'b10, 0, 0, TMO, 32'h12345678, "timeout");
    endtask

    task automatic test_rw_both();
        run_access(1, 1, 32'h204, 32'hCAFEF00D, 2'b10, 2'b10, 0, 1, 32'h1, "rw_both");
    endtask

    task automatic test_ack_idle();
        @(negedge clk);
        dbus_ack = 1; dbus_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dbus_req !== 1'b0 || stall_mem !== 1'b0 || load_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL ack_idle: req=%b stall=%b ldv=%b want 0",
                     dbus_req, stall_mem, load_data_valid);
        end
        dbus_ack = 0;
        run_access(1, 0, 32'h8, 0, 2'b10, 0, 0, 2, 32'h0BADF00D, "after_idle_ack");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_valid = 1; mem_mem_read = 1; mem_mem_write = 0;
        mem_alu_result = 32'h200; mem_load_size = 2'b10;
        repeat (4) @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if (dbus_req !== 1'b0 || stall_mem !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: req=%b stall=%b want 0/0", dbus_req, stall_mem);
        end
        @(negedge clk);
        rst = 0;
        mem_valid = 0;
        run_access(1, 0, 32'h104, 0, 2'b10, 0, 0, 1, 32'h5A5A1234, "post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit rd, wr;
            int k;
            k = $urandom_range(1, 3);
            rd = k[0];
            wr = k[1];
            run_access(rd, wr, $urandom, $urandom, 2'($urandom), 2'($urandom),
                       1'($urandom), $urandom_range(0, 3), $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_timeout();
        test_rw_both();
        test_ack_idle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
